// File: rtl/router_pkg.sv
// Shared types and default sizes for the 1-in/3-out packet router.
package router_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMEOUT    = 30;

  // Header address that selects no destination.
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE,
    LOAD_FIRST,
    LOAD_DATA,
    FIFO_FULL,
    LOAD_PARITY,
    CHECK_PARITY,
    WAIT_EMPTY
  } state_t;

endpackage

// File: rtl/router_fifo.sv
// Per-destination byte FIFO: synchronous write/read, registered read data,
// single-cycle flush. Writes into a full FIFO and reads from an empty one are ignored.
module router_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             read,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             last_slot
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LAST_CNT = (AW + 1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign last_slot = (count == LAST_CNT);
  assign do_wr     = write && !full && !flush;
  assign do_rd     = read && !empty && !flush;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; emptiness is tracked by count alone.
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Registered read data: updates only on a real pop, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst)        dout <= '0;
    else if (do_rd) dout <= mem[rd_ptr];
  end

endmodule

// File: rtl/router_modport.sv
// Packet router top: header decode FSM, running parity and three destination FIFOs.
// Optional timeout flush of stalled destinations is enabled by ROUTER_SOFT_RESET_EN.
module router_modport
  import router_pkg::*;
#(
  parameter int DATA_W     = router_pkg::DATA_W,
  parameter int FIFO_DEPTH = router_pkg::FIFO_DEPTH
`ifdef ROUTER_SOFT_RESET_EN
  ,
  parameter int TIMEOUT    = router_pkg::TIMEOUT
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              err,
  input  logic              read_enb_0,
  input  logic              read_enb_1,
  input  logic              read_enb_2,
  output logic              valid_out_0,
  output logic              valid_out_1,
  output logic              valid_out_2,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2
);

  state_t state, next_state;

  logic [DATA_W-1:0] hdr_q;
  logic [DATA_W-1:0] par_q;
  logic [DATA_W-1:0] run_par;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] dout_v [3];
  logic              wr_en;
  logic [1:0]        addr;
  logic [2:0]        wr_v;
  logic [2:0]        rd_v;
  logic [2:0]        flush_v;
  logic [3:0]        empty_v;
  logic [3:0]        full_v;
  logic [3:0]        last_v;
  logic [3:0]        pop_v;
  logic              becomes_full;

  // Slot 3 of the per-destination vectors stands for the invalid address.
  assign empty_v[3] = 1'b0;
  assign full_v[3]  = 1'b0;
  assign last_v[3]  = 1'b0;

  assign rd_v  = {read_enb_2, read_enb_1, read_enb_0};
  assign pop_v = {1'b0, rd_v & ~empty_v[2:0]};

  // While decoding, the address comes straight off the bus; afterwards from the latched header.
  assign addr         = (state == DECODE) ? data_in[1:0] : hdr_q[1:0];
  assign becomes_full = last_v[addr] && !pop_v[addr];
  assign wr_v         = wr_en ? (3'b001 << addr) : 3'b000;

  for (genvar i = 0; i < 3; i++) begin : g_fifo
    router_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .write     (wr_v[i]),
      .read      (rd_v[i]),
      .flush     (flush_v[i]),
      .din       (wr_data),
      .dout      (dout_v[i]),
      .full      (full_v[i]),
      .empty     (empty_v[i]),
      .last_slot (last_v[i])
    );
  end

  assign valid_out_0 = !empty_v[0];
  assign valid_out_1 = !empty_v[1];
  assign valid_out_2 = !empty_v[2];
  assign data_out_0  = dout_v[0];
  assign data_out_1  = dout_v[1];
  assign data_out_2  = dout_v[2];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= DECODE;
    else     state <= next_state;
  end

  // Next-state, busy and FIFO write control.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_state = state;
    busy       = 1'b0;
    wr_en      = 1'b0;
    wr_data    = data_in;
    case (state)
      DECODE: begin
        if (pkt_valid && data_in[1:0] != ADDR_INVALID)
          next_state = empty_v[addr] ? LOAD_FIRST : WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (empty_v[addr]) next_state = LOAD_FIRST;
      end
      LOAD_FIRST: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        wr_data    = hdr_q;
        next_state = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (pkt_valid) begin
          wr_en = 1'b1;
          if (becomes_full) next_state = FIFO_FULL;
        end else begin
          next_state = LOAD_PARITY;
        end
      end
      FIFO_FULL: begin
        busy = 1'b1;
        if (!full_v[addr]) next_state = LOAD_DATA;
      end
      LOAD_PARITY: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        wr_data    = par_q;
        next_state = CHECK_PARITY;
      end
      CHECK_PARITY: begin
        busy       = 1'b1;
        next_state = DECODE;
      end
      default: next_state = DECODE;
    endcase
  end

  // Header latch, received parity byte, running parity and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q   <= '0;
      par_q   <= '0;
      run_par <= '0;
      err     <= 1'b0;
    end else begin
      if (state == DECODE && pkt_valid)     hdr_q <= data_in;
      if (state == LOAD_DATA && !pkt_valid) par_q <= data_in;
      if (state == LOAD_FIRST) begin
        run_par <= hdr_q;
        err     <= 1'b0;
      end else if (state == LOAD_DATA && pkt_valid) begin
        run_par <= run_par ^ data_in;
      end
      if (state == CHECK_PARITY) err <= (par_q != run_par);
    end
  end

`ifdef ROUTER_SOFT_RESET_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt [3];

  for (genvar i = 0; i < 3; i++) begin : g_tmo
    assign flush_v[i] = (tmo_cnt[i] == TW'(TIMEOUT));

    // Count cycles a non-empty destination goes unread; flush it when the budget runs out.
    always_ff @(posedge clk) begin
      if (rst || empty_v[i] || rd_v[i] || flush_v[i]) tmo_cnt[i] <= '0;
      else                                           tmo_cnt[i] <= tmo_cnt[i] + 1'b1;
    end
  end
`else
  assign flush_v = 3'b000;
`endif

endmodule

// File: tb/tb_router_modport.sv
// Directed bench for router_modport with a per-destination byte scoreboard.
module tb_router_modport;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, err;
  logic [2:0] read_enb = 3'b000;
  logic [2:0] valid_out;
  logic [7:0] data_out [3];

  int   vectors = 0;
  int   miscompares = 0;
  int   sent_cnt = 0;
  bq_t  exp_q [3];
  bq_t  got_q [3];
  logic [2:0] pend = 3'b000;
  logic [7:0] e_mon;

  always #5 clk = ~clk;

  router_modport dut (
    .clk         (clk),
    .rst         (rst),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .busy        (busy),
    .err         (err),
    .read_enb_0  (read_enb[0]),
    .read_enb_1  (read_enb[1]),
    .read_enb_2  (read_enb[2]),
    .valid_out_0 (valid_out[0]),
    .valid_out_1 (valid_out[1]),
    .valid_out_2 (valid_out[2]),
    .data_out_0  (data_out[0]),
    .data_out_1  (data_out[1]),
    .data_out_2  (data_out[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packet = header, n payload bytes (first, first+stp, ...), XOR parity of everything before it.
  function automatic bq_t mk(input logic [7:0] hdr, input int n, input logic [7:0] first,
                             input logic [7:0] stp);
    bq_t r;
    logic [7:0] p, b;
    r.push_back(hdr);
    p = hdr;
    b = first;
    for (int k = 0; k < n; k++) begin
      r.push_back(b);
      p = p ^ b;
      b = b + stp;
    end
    r.push_back(p);
    return r;
  endfunction

  // Source side: each byte is held until a clock edge sees busy low.
  task automatic send(input bq_t bytes, input bit with_parity);
    int   guard;
    bit   b;
    logic [7:0] hdr;
    hdr = bytes[0];
    if (hdr[1:0] != 2'd3)
      foreach (bytes[k]) exp_q[hdr[1:0]].push_back(bytes[k]);
    for (int k = 0; k < bytes.size(); k++) begin
      pkt_valid = !(with_parity && k == bytes.size() - 1);
      data_in   = bytes[k];
      guard = 0;
      do begin
        @(negedge clk);
        b = busy;
        @(posedge clk);
        #1;
        guard++;
      end while (b && guard < 300);
      if (b) check("send_hold_budget", 32'(b), 32'd0);
      sent_cnt++;
    end
    pkt_valid = 1'b0;
    data_in   = 8'h00;
  endtask

  // Destination side: hold read_enb until n pops have happened.
  task automatic drain(input int i, input int n);
    int cnt, guard;
    cnt = 0;
    guard = 0;
    read_enb[i] = 1'b1;
    while (cnt < n && guard < 500) begin
      @(negedge clk);
      if (valid_out[i]) cnt++;
      @(posedge clk);
      #1;
      guard++;
    end
    read_enb[i] = 1'b0;
    check($sformatf("drain_count_%0d", i), cnt, n);
    step(1);
  endtask

  // Compare process: every popped byte must be the next expected byte for that destination,
  // and a destination may only report valid while the scoreboard still owes it data.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("pop_unexpected_%0d", i), 32'd1, 32'd0);
        end else begin
          e_mon = exp_q[i].pop_front();
          got_q[i].push_back(data_out[i]);
          check($sformatf("data_out_%0d", i), data_out[i], e_mon);
        end
      end
      pend[i] = !rst && read_enb[i] && valid_out[i];
      if (!rst && valid_out[i] === 1'b1)
        check($sformatf("valid_out_%0d_owed", i), 32'(exp_q[i].size() > 0), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t pk, pa, pb;
    logic [7:0] lit0 [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    int base, n, g;

    // Reset state.
    step(3);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid_%0d", i), valid_out[i], 0);
      check($sformatf("rst_data_%0d", i), data_out[i], 0);
    end

    // Good packet to destination 0; the byte stream is pinned by literals.
    pk = mk(8'h0C, 3, 8'h11, 8'h11);
    check("parity_model", pk[4], 8'h0C);
    send(pk, 1'b1);
    step(2);
    check("p0_valid0", valid_out[0], 1);
    check("p0_valid1", valid_out[1], 0);
    check("p0_valid2", valid_out[2], 0);
    check("p0_busy", busy, 0);
    check("p0_err", err, 0);
    got_q[0].delete();
    drain(0, 5);
    check("p0_got_size", got_q[0].size(), 5);
    for (int k = 0; k < 5 && k < got_q[0].size(); k++)
      check($sformatf("p0_byte_%0d", k), got_q[0][k], lit0[k]);

    // Invalid address: header ignored.
    pk = '{};
    pk.push_back(8'h0F);
    send(pk, 1'b0);
    step(3);
    check("a3_busy", busy, 0);
    for (int i = 0; i < 3; i++) check($sformatf("a3_valid_%0d", i), valid_out[i], 0);

    // Bad parity to destination 2, then a good packet clears err at LOAD_FIRST.
    pk = mk(8'h0E, 3, 8'h11, 8'h11);
    pk[4] = 8'hFF;
    send(pk, 1'b1);
    step(1);
    check("bad_err_before_check", err, 0);
    step(1);
    check("bad_err_set", err, 1);
    drain(2, 5);
    check("bad_err_held", err, 1);
    base = sent_cnt;
    fork
      send(mk(8'h0E, 3, 8'h11, 8'h11), 1'b1);
      begin
        g = 0;
        while (sent_cnt == base && g < 50) begin
          step(1);
          g++;
        end
        step(1);
        #1;
        check("err_cleared_at_load_first", err, 0);
      end
    join
    step(2);
    check("good_err", err, 0);
    drain(2, 5);

    // Long packet to destination 1 with no reader: source stalls once 16 bytes are stored.
    base = sent_cnt;
    fork
      send(mk(8'h51, 20, 8'h01, 8'h01), 1'b1);
      begin
        step(20);
        #1;
        check("full_busy", busy, 1);
        check("full_bytes_taken", sent_cnt - base, 16);
        check("full_valid1", valid_out[1], 1);
        drain(1, 22);
      end
    join
    check("long_all_delivered", exp_q[1].size(), 0);

    // Second packet to a non-empty destination waits until it is drained.
    pa = mk(8'h0C, 3, 8'h11, 8'h11);
    pb = mk(8'h08, 2, 8'hAA, 8'h11);
    check("pb_parity_model", pb[3], 8'h19);
    send(pa, 1'b1);
    base = sent_cnt;
    fork
      send(pb, 1'b1);
      begin
        step(6);
        #1;
        check("wait_empty_busy", busy, 1);
        check("wait_empty_hdr_only", sent_cnt - base, 1);
        check("wait_empty_valid0", valid_out[0], 1);
        drain(0, 5);
      end
    join
    step(2);
    drain(0, 4);
    check("wait_empty_err", err, 0);

`ifdef ROUTER_SOFT_RESET_EN
    // Stalled destination is flushed 31 cycles after it goes non-empty.
    fork
      send(mk(8'h14, 5, 8'h01, 8'h01), 1'b1);
      begin
        g = 0;
        while (!valid_out[0] && g < 50) begin
          @(negedge clk);
          g++;
        end
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (valid_out[0] && n < 100);
        check("timeout_cycles", n, 31);
      end
    join
    exp_q[0].delete();
    step(1);
    check("timeout_valid0", valid_out[0], 0);
`else
    // Without the timeout flush a stalled destination keeps its bytes.
    send(mk(8'h14, 5, 8'h01, 8'h01), 1'b1);
    step(40);
    check("no_timeout_valid0", valid_out[0], 1);
    drain(0, 7);
`endif

    // Reset in the middle of a packet discards it and returns to DECODE.
    exp_q[0].push_back(8'h0C);
    exp_q[0].push_back(8'h11);
    exp_q[0].push_back(8'h22);
    pkt_valid = 1'b1;
    data_in   = 8'h0C;
    step(1);
    data_in = 8'h11;
    step(2);
    data_in = 8'h22;
    step(1);
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    rst       = 1'b1;
    step(1);
    exp_q[0].delete();
    rst = 1'b0;
    check("midrst_valid0", valid_out[0], 0);
    check("midrst_busy", busy, 0);
    check("midrst_data0", data_out[0], 0);
    check("midrst_err", err, 0);
    send(mk(8'h05, 1, 8'h5A, 8'h00), 1'b1);
    step(2);
    drain(1, 3);

    for (int i = 0; i < 3; i++) check($sformatf("final_empty_%0d", i), exp_q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_modport.md
Name: router_modport

Overview:
- 1-input, 3-output packet router.
- A source pushes byte-serial packets: header, payload, parity.
- The header's 2-bit address steers the packet into one of three per-destination FIFOs.
- Each destination drains its FIFO with its own read_enb/valid_out handshake. The router checks parity and flushes any FIFO whose reader stalls too long.

Parameters:
- DATA_W, 8, byte width of data_in/data_out.
- FIFO_DEPTH, 16, entries per destination FIFO (power of 2).
- TIMEOUT, 30, consecutive unserviced cycles before a soft-reset flush.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pkt_valid  in  1  source byte valid (header and payload)
- data_in  in  8  source byte
- busy  out  1  source must hold data_in/pkt_valid while high
- err  out  1  parity mismatch on last packet
- read_enb_0/1/2  in  1  destination i pops one byte
- valid_out_0/1/2  out  1  destination i FIFO non-empty
- data_out_0/1/2  out  8  destination i byte (registered)

Behaviour:
- Packet format:
  - header = {len[7:2], addr[1:0]}, len 1..63.
  - Then len payload bytes, all with pkt_valid=1.
  - Then one parity byte with pkt_valid=0, in the cycle immediately after the last payload.
  - parity = XOR of header and all payload bytes.
- Reset (rst=1 at posedge): FSM->DECODE, all FIFOs emptied, busy=0, err=0, valid_out_*=0, data_out_*=0, timeout counters=0.
- FSM states: DECODE, LOAD_FIRST, LOAD_DATA, FIFO_FULL, LOAD_PARITY, CHECK_PARITY, WAIT_EMPTY.
- DECODE (busy=0), on pkt_valid=1:
  - addr==3: header ignored, stay in DECODE.
  - FIFO[addr] empty: -> LOAD_FIRST.
  - FIFO[addr] not empty: -> WAIT_EMPTY (busy=1); header is latched.
- WAIT_EMPTY: busy=1; -> LOAD_FIRST when FIFO[addr] empty.
- LOAD_FIRST: busy=1; write header; init running parity = header; clear err; -> LOAD_DATA.
- LOAD_DATA: busy=0.
  - pkt_valid=1: write byte, XOR into parity; if FIFO becomes full -> FIFO_FULL.
  - pkt_valid=0: -> LOAD_PARITY.
- FIFO_FULL: busy=1; no writes; -> LOAD_DATA when not full.
- LOAD_PARITY: busy=1; write the parity byte to FIFO; compare with running parity; -> CHECK_PARITY.
- CHECK_PARITY: busy=1; err <= mismatch, held until next LOAD_FIRST; -> DECODE.
- FIFO: synchronous write/read; pointers wrap modulo FIFO_DEPTH.
  - Full write is blocked by the FSM; never overwrite.
  - Simultaneous read and write on the same FIFO is legal; count unchanged.
- Destination i:
  - valid_out_i = FIFO non-empty (combinational from count).
  - read_enb_i while non-empty: data_out_i updates at the next posedge with the head byte (1-cycle latency).
  - read_enb_i while empty: no pop, data_out_i holds.
- Timeout: counter_i increments each cycle valid_out_i=1 and read_enb_i=0.
  - Counter clears on read_enb_i=1 or empty.
  - When it reaches TIMEOUT, FIFO_i is flushed next cycle and the counter clears.
- Flush while the FSM is loading that FIFO: the remainder of the packet continues writing into the emptied FIFO; the FSM is not aborted.
- rst mid-packet: immediate return to DECODE; the partial packet is discarded.

Optional Feature:
- ROUTER_SOFT_RESET_EN defined: timeout flush active as above.
- Undefined: timeout counters and flush logic omitted; bytes wait indefinitely for read_enb.

Decomposition:
- router_pkg holds:
  - state enum state_t;
  - ADDR_INVALID=2'd3;
  - DATA_W, FIFO_DEPTH, TIMEOUT defaults.
- Sub-module router_fifo (DATA_W x FIFO_DEPTH, write/read/flush, full/empty), instantiated 3x.
- FSM, parity and timeout counters live in the top.

Test Plan:
- Packet header 8'h0C (len 3, addr 0), payload 11,22,33, correct parity 8'h0C^11^22^33; then read_enb_0 -> valid_out_0=1; data_out_0 sequence 0C,11,22,33,parity; err=0; FIFO_1/FIFO_2 untouched.
- Same packet to addr 2 with parity byte 8'hFF (wrong) -> err=1 after CHECK_PARITY, cleared at the next packet's LOAD_FIRST.
- Header addr 3 (8'h0F) -> no FIFO write; busy=0; all valid_out=0.
- len 20 to addr 1, read_enb_1=0 -> busy rises in FIFO_FULL after 16 writes; source holds; reading resumes loading; all 22 bytes delivered in order.
- ROUTER_SOFT_RESET_EN: 5-byte packet to addr 0, read_enb_0 held low -> valid_out_0 drops 31 cycles after the FIFO goes non-empty.
- Second packet to addr 0 while FIFO_0 non-empty -> busy=1 (WAIT_EMPTY) until it is drained, then the packet loads correctly.
